// File: rtl/dvsd_irq_pkg.sv
// rtl/dvsd_irq_pkg.sv - shared constants and state type for the interrupt controller
package dvsd_irq_pkg;

   localparam int N_SRC = 8;
   localparam int VEC_W = 3;

   localparam logic [N_SRC-1:0] MASK_RST = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      ARB,
      WAIT,
      CLR
   } irq_state_t;

endpackage

// File: rtl/dvsd_irq_pick.sv
// rtl/dvsd_irq_pick.sv - 8-to-3 pick: first set bit of eff searching down from base with wrap
module dvsd_irq_pick
   import dvsd_irq_pkg::*;
(
   input  logic [N_SRC-1:0] eff,
   input  logic [VEC_W-1:0] base,
   output logic [VEC_W-1:0] vec,
   output logic             valid
);

   logic [VEC_W-1:0] idx;

   always_comb begin
      vec   = '0;
      valid = 1'b0;
      idx   = '0;
      // base, base-1, ... wrapping through 0 back to base+1
      for (int i = 0; i < N_SRC; i++) begin
         idx = base - VEC_W'(i);
         if (!valid && eff[idx]) begin
            vec   = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dvsd_irq_ctrl.sv
// rtl/dvsd_irq_ctrl.sv - eight-source interrupt controller with ack handshake and timeout
// Optional rotating priority: DVSD_IRQ_RR_EN.
module dvsd_irq_ctrl
   import dvsd_irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] req,
   input  logic             en,
   input  logic             mask_wr,
   input  logic [N_SRC-1:0] mask_din,
   output logic [N_SRC-1:0] mask_q,
   output logic [N_SRC-1:0] pend,
   output logic             irq,
   output logic [VEC_W-1:0] vec,
   input  logic             ack,
   output logic             busy,
   output logic             tmo
);

   localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   logic [N_SRC-1:0] sync_q [SYNC_STAGES];
   logic [N_SRC-1:0] edge_q, rise, eff, clr_bits;
   logic [N_SRC-1:0] mask_r, pend_r;
   irq_state_t       state, state_n;
   logic             irq_r, irq_n, tmo_r, tmo_n, clr;
   logic [VEC_W-1:0] vec_r, vec_n, base, pick_vec;
   logic             pick_valid;
   logic [CNT_W-1:0] cnt, cnt_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         edge_q <= '0;
      end else begin
         sync_q[0] <= req;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise     = sync_q[SYNC_STAGES-1] & ~edge_q;
   assign eff      = pend_r & ~mask_r;
   assign clr_bits = clr ? (N_SRC'(1) << vec_r) : '0;

   // a fresh edge on the source being cleared keeps it pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_r <= '0;
         mask_r <= MASK_RST;
      end else begin
         pend_r <= (pend_r & ~clr_bits) | rise;
         if (mask_wr) mask_r <= mask_din;
      end
   end

`ifdef DVSD_IRQ_RR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      base <= VEC_W'(N_SRC-1);
      else if (clr) base <= vec_r - 1'b1;
   end
`else
   assign base = VEC_W'(N_SRC-1);
`endif

   dvsd_irq_pick u_pick (
      .eff   (eff),
      .base  (base),
      .vec   (pick_vec),
      .valid (pick_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         irq_r <= 1'b0;
         vec_r <= '0;
         tmo_r <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         irq_r <= irq_n;
         vec_r <= vec_n;
         tmo_r <= tmo_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      irq_n   = irq_r;
      vec_n   = vec_r;
      tmo_n   = 1'b0;
      cnt_n   = cnt;
      clr     = 1'b0;
      unique case (state)
         IDLE: if (en && eff != '0) state_n = ARB;
         ARB: begin
            cnt_n = '0;
            // eff can vanish if the mask changed on the way into ARB
            if (pick_valid) begin
               vec_n   = pick_vec;
               irq_n   = 1'b1;
               state_n = WAIT;
            end else begin
               state_n = IDLE;
            end
         end
         WAIT: begin
            if (ack) begin
               clr     = 1'b1;
               irq_n   = 1'b0;
               state_n = CLR;
            end else if (ACK_TIMEOUT != 0 && cnt == CNT_W'(ACK_TIMEOUT-1)) begin
               tmo_n   = 1'b1;
               irq_n   = 1'b0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         CLR:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign mask_q = mask_r;
   assign pend   = pend_r;
   assign irq    = irq_r;
   assign vec    = vec_r;
   assign tmo    = tmo_r;
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dvsd_irq_ctrl.sv
// tb/tb_dvsd_irq_ctrl.sv - scoreboard bench for dvsd_irq_ctrl
module tb_dvsd_irq_ctrl;

   logic       clk, rst, en, mask_wr, ack;
   logic [7:0] req, mask_din, mask_q, pend;
   logic       irq, busy, tmo;
   logic [2:0] vec;

   int n_cmp = 0;
   int n_bad = 0;
   logic [2:0] exp_q[$];
   logic       irq_d = 1'b0;

   dvsd_irq_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .en       (en),
      .mask_wr  (mask_wr),
      .mask_din (mask_din),
      .mask_q   (mask_q),
      .pend     (pend),
      .irq      (irq),
      .vec      (vec),
      .ack      (ack),
      .busy     (busy),
      .tmo      (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // each rising irq is a grant: its vector must match the oldest expectation
   always @(negedge clk) begin
      if (irq && !irq_d) begin
         if (exp_q.size() == 0) chk("sb_grant_without_expect", exp_q.size(), 1);
         else                   chk("sb_vec", vec, exp_q.pop_front());
      end
      irq_d = irq;
   end

   task automatic wait_pend(input string tag, input logic [7:0] exp);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (pend == exp) break;
      end
      chk(tag, pend, exp);
   endtask

   task automatic wait_irq(input string tag);
      int i;
      for (i = 0; i < 40; i++) begin
         @(negedge clk);
         if (irq) break;
      end
      if (i == 40) chk(tag, irq, 1);
   endtask

   task automatic do_ack(input string tag);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk(tag, irq, 0);
   endtask

   task automatic write_mask(input logic [7:0] v);
      mask_wr  = 1'b1;
      mask_din = v;
      @(negedge clk);
      mask_wr  = 1'b0;
      chk("mask_q", mask_q, v);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic seen;
      rst = 1'b1; req = '0; en = 1'b1; mask_wr = 1'b0; mask_din = '0; ack = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_pend", pend, 0);
      chk("rst_irq", irq, 0);
      chk("rst_vec", vec, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tmo", tmo, 0);
      chk("rst_mask", mask_q, 0);

      // single source, latency and ack
      exp_q.push_back(3'd0);
      req = 8'h01;
      wait_pend("t1_pend", 8'h01);
      @(negedge clk);
      chk("t1_arb_irq", irq, 0);
      chk("t1_arb_busy", busy, 1);
      @(negedge clk);
      chk("t1_irq_lat", irq, 1);
      req = 8'h00;
      do_ack("t1_ack_irq");
      chk("t1_pend_clr", pend, 0);
      chk("t1_clr_busy", busy, 1);
      @(negedge clk);
      chk("t1_idle_busy", busy, 0);

      // two sources, fixed priority
      exp_q.push_back(3'd5);
      exp_q.push_back(3'd2);
      req = 8'h24;
      wait_pend("t2_pend", 8'h24);
      wait_irq("t2_irq5");
      do_ack("t2_ack5");
      chk("t2_pend_after5", pend, 8'h04);
      wait_irq("t2_irq2");
      do_ack("t2_ack2");
      chk("t2_pend_end", pend, 8'h00);
      req = 8'h00;
      repeat (3) @(negedge clk);

      // masked source captures but is not granted
      write_mask(8'h20);
      exp_q.push_back(3'd2);
      req = 8'h24;
      wait_pend("t3_pend", 8'h24);
      wait_irq("t3_irq2");
      do_ack("t3_ack2");
      chk("t3_pend_masked", pend, 8'h20);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | irq;
      end
      chk("t3_masked_no_irq", seen, 0);
      exp_q.push_back(3'd5);
      write_mask(8'h00);
      wait_irq("t3_irq5");
      do_ack("t3_ack5");
      chk("t3_pend_end", pend, 8'h00);
      req = 8'h00;
      repeat (3) @(negedge clk);

      // timeout after 16 WAIT cycles, then re-grant
      exp_q.push_back(3'd3);
      req = 8'h08;
      wait_irq("t4_irq");
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         seen = seen | tmo | ~irq;
      end
      chk("t4_hold", seen, 0);
      @(negedge clk);
      chk("t4_tmo", tmo, 1);
      chk("t4_irq_drop", irq, 0);
      chk("t4_pend_kept", pend, 8'h08);
      exp_q.push_back(3'd3);
      @(negedge clk);
      chk("t4_tmo_pulse", tmo, 0);
      chk("t4_arb_irq", irq, 0);
      @(negedge clk);
      chk("t4_regrant", irq, 1);
      do_ack("t4_ack");
      chk("t4_pend_end", pend, 8'h00);
      req = 8'h00;
      repeat (3) @(negedge clk);

      // en=0 holds off arbitration
      en = 1'b0;
      req = 8'h80;
      wait_pend("t5_pend", 8'h80);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | irq;
      end
      chk("t5_blocked", seen, 0);
      exp_q.push_back(3'd7);
      en = 1'b1;
      @(negedge clk);
      chk("t5_arb_irq", irq, 0);
      @(negedge clk);
      chk("t5_irq", irq, 1);
      do_ack("t5_ack");
      chk("t5_pend_end", pend, 8'h00);
      req = 8'h00;
      repeat (3) @(negedge clk);

      // asynchronous reset mid-handshake
      exp_q.push_back(3'd1);
      req = 8'h02;
      wait_irq("t6_irq");
      #2 rst = 1'b1;
      #1;
      chk("t6_irq", irq, 0);
      chk("t6_vec", vec, 0);
      chk("t6_pend", pend, 0);
      chk("t6_busy", busy, 0);
      req = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

`ifdef DVSD_IRQ_RR_EN
      // rotating priority alternates between two persistent requesters
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(3'd7);
         exp_q.push_back(3'd0);
         req = 8'h00;
         repeat (4) @(negedge clk);
         req = 8'h81;
         wait_pend("rr_pend", 8'h81);
         wait_irq("rr_irq_a");
         do_ack("rr_ack_a");
         wait_irq("rr_irq_b");
         do_ack("rr_ack_b");
         chk("rr_pend_end", pend, 8'h00);
      end
      req = 8'h00;
      repeat (3) @(negedge clk);
`endif

      chk("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
